// File: rtl/frame_seq_checker.sv
// Receive-side frame sequence checker: locks onto {x,y} segment boundaries, predicts the next {x,y},
// counts sequence errors and completed frames. Define FRAME_CHECK_DATA_EN to add the payload +1 check.
module frame_seq_checker #(
    parameter int XW        = 2,
    parameter int YW        = 11,
    parameter int DW        = 16,
    parameter int SEG_WORDS = 640,
    parameter int SEGS      = 2,
    parameter int LINES     = 720,
    parameter int CW        = 16
) (
    input  logic                  clk125m,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  stop_on_err,
    input  logic                  din_valid,
    input  logic [XW+YW+DW-1:0]   din,
    input  logic [2:0]            sel,
    output logic [7:0]            led,
    output logic                  locked,
    output logic                  err_flag,
    output logic [CW-1:0]         err_count,
    output logic [CW-1:0]         data_err_cnt,
    output logic [CW-1:0]         frame_count,
    output logic [XW+YW+DW-1:0]   cap_din,
    output logic [XW+YW-1:0]      cap_exp
);

    localparam int WW  = XW + YW + DW;
    localparam int AW  = XW + YW;
    localparam int SCW = (SEG_WORDS > 1) ? $clog2(SEG_WORDS) : 1;

    localparam logic [SCW-1:0] SEG_LAST = SCW'(SEG_WORDS - 1);
    localparam logic [SCW-1:0] SEG_ONE  = SCW'(1);
    localparam logic [XW-1:0]  X_LAST   = XW'(SEGS - 1);
    localparam logic [XW-1:0]  X_ONE    = XW'(1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(LINES - 1);
    localparam logic [YW-1:0]  Y_ONE    = YW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   prev_xy_q, prev_xy_d;
    logic [XW-1:0]   exp_x_q, exp_x_d;
    logic [YW-1:0]   exp_y_q, exp_y_d;
    logic [SCW-1:0]  seg_cnt_q, seg_cnt_d;
    logic            err_flag_q, err_flag_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic [CW-1:0]   frame_count_q, frame_count_d;
    logic [WW-1:0]   cap_din_q, cap_din_d;
    logic [AW-1:0]   cap_exp_q, cap_exp_d;

    logic [AW-1:0]   din_xy;
    logic [AW-1:0]   exp_xy;

    assign din_xy = din[WW-1 -: AW];
    assign exp_xy = {exp_x_q, exp_y_q};

`ifdef FRAME_CHECK_DATA_EN
    localparam logic [DW-1:0] DATA_ONE = DW'(1);

    logic [DW-1:0]   din_data;
    logic [DW-1:0]   prev_data_q, prev_data_d;
    logic [CW-1:0]   data_err_cnt_q, data_err_cnt_d;

    assign din_data = din[DW-1:0];
`endif

    always_comb begin
        state_d       = state_q;
        prev_xy_d     = prev_xy_q;
        exp_x_d       = exp_x_q;
        exp_y_d       = exp_y_q;
        seg_cnt_d     = seg_cnt_q;
        err_flag_d    = err_flag_q;
        err_count_d   = err_count_q;
        frame_count_d = frame_count_q;
        cap_din_d     = cap_din_q;
        cap_exp_d     = cap_exp_q;
`ifdef FRAME_CHECK_DATA_EN
        prev_data_d    = prev_data_q;
        data_err_cnt_d = data_err_cnt_q;
`endif

        if (din_valid && state_q != HALT) begin
            prev_xy_d = din_xy;
`ifdef FRAME_CHECK_DATA_EN
            prev_data_d = din_data;
`endif
        end

        if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end
                // A change of {x,y} against the previous word marks word 0 of a new segment.
                SYNC: begin
                    if (din_xy != prev_xy_q) begin
                        state_d   = CHECK;
                        exp_x_d   = din[WW-1 -: XW];
                        exp_y_d   = din[DW +: YW];
                        seg_cnt_d = SEG_ONE;
                    end
                end
                CHECK: begin
                    if (din_xy == exp_xy) begin
`ifdef FRAME_CHECK_DATA_EN
                        if (seg_cnt_q != '0 && din_data != prev_data_q + DATA_ONE &&
                            data_err_cnt_q != '1) begin
                            data_err_cnt_d = data_err_cnt_q + CNT_ONE;
                        end
`endif
                        if (seg_cnt_q == SEG_LAST) begin
                            seg_cnt_d = '0;
                            if (exp_x_q == X_LAST) begin
                                exp_x_d = '0;
                                if (exp_y_q == Y_LAST) begin
                                    exp_y_d       = '0;
                                    frame_count_d = frame_count_q + CNT_ONE;
                                end else begin
                                    exp_y_d = exp_y_q + Y_ONE;
                                end
                            end else begin
                                exp_x_d = exp_x_q + X_ONE;
                            end
                        end else begin
                            seg_cnt_d = seg_cnt_q + SEG_ONE;
                        end
                    end else begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_ONE;
                        end
                        err_flag_d = 1'b1;
                        if (!err_flag_q) begin
                            cap_din_d = din;
                            cap_exp_d = exp_xy;
                        end
                        state_d = stop_on_err ? HALT : SYNC;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Reset and clear share one path; a word arriving alongside either is discarded.
    always_ff @(posedge clk125m) begin
        if (reset || clear) begin
            state_q       <= IDLE;
            prev_xy_q     <= '0;
            exp_x_q       <= '0;
            exp_y_q       <= '0;
            seg_cnt_q     <= '0;
            err_flag_q    <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
            cap_din_q     <= '0;
            cap_exp_q     <= '0;
`ifdef FRAME_CHECK_DATA_EN
            prev_data_q    <= '0;
            data_err_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            prev_xy_q     <= prev_xy_d;
            exp_x_q       <= exp_x_d;
            exp_y_q       <= exp_y_d;
            seg_cnt_q     <= seg_cnt_d;
            err_flag_q    <= err_flag_d;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
            cap_din_q     <= cap_din_d;
            cap_exp_q     <= cap_exp_d;
`ifdef FRAME_CHECK_DATA_EN
            prev_data_q    <= prev_data_d;
            data_err_cnt_q <= data_err_cnt_d;
`endif
        end
    end

    assign locked      = (state_q == CHECK);
    assign err_flag    = err_flag_q;
    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;
    assign cap_din     = cap_din_q;
    assign cap_exp     = cap_exp_q;
`ifdef FRAME_CHECK_DATA_EN
    assign data_err_cnt = data_err_cnt_q;
`else
    assign data_err_cnt = '0;
`endif

    // Shifting {x,y} right by 8 yields {x, y[YW-1:8]} zero-extended (assumes YW >= 8).
    always_comb begin
        led = 8'h00;
        unique case (sel)
            3'd0:    led = 8'(cap_din_q[DW +: YW]);
            3'd1:    led = 8'(cap_din_q[WW-1 -: AW] >> 8);
            3'd2:    led = 8'(cap_exp_q[YW-1:0]);
            3'd3:    led = 8'(cap_exp_q >> 8);
            3'd4:    led = 8'(err_count_q);
            3'd5:    led = 8'(frame_count_q);
            3'd6:    led = {locked, err_flag_q, state_q, 4'b0000};
            3'd7:    led = 8'(data_err_cnt);
            default: led = 8'h00;
        endcase
    end

endmodule
